lbist_misr: RTL and testbench

Response compactor for the logic BIST path: the receiving end of the pseudo-random pattern generator. It folds each captured scan/response word into a multiple-input signature register (MISR) for a programmed number of test cycles. It then compares the final signature against a golden value and reports pass/fail to the BIST controller. It sits between the core's response capture outputs and the BIST controller's status inputs.

---
 rtl/lbist_pkg.sv | 14 +
 rtl/lbist_misr_core.sv | 28 ++
 rtl/lbist_misr.sv | 104 ++++++++++
 tb/tb_lbist_misr.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lbist_pkg.sv
// Shared types and defaults for the logic-BIST response compactor.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } misr_state_t;

  localparam logic [31:0] MISR_POLY_DEF  = 32'h04C11DB7;
  localparam int          MISR_LEN_W_DEF = 16;

endpackage

// File: rtl/lbist_misr_core.sv
// Galois-form multiple-input signature register: seed load, gated update.
module misr_core
  import lbist_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_DEF),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] fb;

  // Shift toward the MSB; the bit falling off the top folds back through the taps.
  assign fb = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sig <= SEED;
    else if (load) sig <= SEED;
    else if (en)   sig <= fb ^ d;
  end

endmodule

// File: rtl/lbist_misr.sv
// LBIST response compactor: run FSM, word counter and golden compare around misr_core.
// Optional X-masking of response bits is enabled with LBIST_MISR_XMASK_EN.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_DEF),
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               LEN_W = MISR_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] test_len,
  input  logic [WIDTH-1:0] golden,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
`ifdef LBIST_MISR_XMASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  misr_state_t      state, state_nxt;
  logic [LEN_W-1:0] cnt, len, last_idx;
  logic             sig_load, sig_en;
  logic [WIDTH-1:0] d;

`ifdef LBIST_MISR_XMASK_EN
  assign d = resp_data & ~resp_mask;
`else
  assign d = resp_data;
`endif

  // Index of the final word; wraps harmlessly when len is 0 since RUN is skipped then.
  assign last_idx = len - 1'b1;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sig_load),
    .en    (sig_en),
    .d     (d),
    .sig   (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    sig_load  = 1'b0;
    sig_en    = 1'b0;
    case (state)
      IDLE: if (start) begin
        sig_load  = 1'b1;
        state_nxt = (test_len == '0) ? CMP : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (resp_valid) begin
          sig_en = 1'b1;
          if (cnt == last_idx) state_nxt = CMP;
        end
      end
      CMP: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      len  <= '0;
      pass <= 1'b0;
    end else if (sig_load) begin
      cnt  <= '0;
      len  <= test_len;
      pass <= 1'b0;
    end else begin
      if (sig_en)         cnt  <= cnt + 1'b1;
      if (state == CMP)   pass <= (signature == golden);
    end
  end

endmodule

// File: tb/tb_lbist_misr.sv
// Directed bench for lbist_misr (WIDTH=8, POLY=8'h1D, SEED=0) with a cycle-level reference model.
module tb_lbist_misr;

  localparam int W  = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          resp_valid = 1'b0;
  logic [LW-1:0] test_len = '0;
  logic [W-1:0]  golden = '0;
  logic [W-1:0]  resp_data = '0;
`ifdef LBIST_MISR_XMASK_EN
  logic [W-1:0]  resp_mask = '0;
  logic [W-1:0]  mask0 = '0;
`endif
  logic          busy, done, pass;
  logic [W-1:0]  signature;

  always #5 clk = ~clk;

  lbist_misr #(
    .WIDTH (W),
    .POLY  (8'h1D),
    .SEED  (8'h00),
    .LEN_W (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .test_len   (test_len),
    .golden     (golden),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
`ifdef LBIST_MISR_XMASK_EN
    .resp_mask  (resp_mask),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
  );

  // Signature update as GF(2) polynomial arithmetic: multiply by x modulo x^8+x^4+x^3+x^2+1, add the word.
  function automatic logic [7:0] gf_step(input logic [7:0] s, input logic [7:0] dw);
    logic [8:0] t;
    t = {s, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0] ^ dw;
  endfunction

  logic [W-1:0] d_eff;
`ifdef LBIST_MISR_XMASK_EN
  assign d_eff = resp_data & ~resp_mask;
`else
  assign d_eff = resp_data;
`endif

  // Model: words still owed, a pending compare, and the done pulse.
  logic [7:0] m_sig  = 8'h00;
  logic       m_pass = 1'b0;
  logic       m_done = 1'b0;
  logic       m_due  = 1'b0;
  int         m_left = 0;
  logic       m_busy;
  assign m_busy = (m_left > 0) || m_due;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sig <= 8'h00; m_pass <= 1'b0; m_done <= 1'b0; m_due <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_due) begin
        m_pass <= (m_sig == golden);
        m_due  <= 1'b0;
        m_done <= 1'b1;
      end else if (m_left > 0) begin
        if (resp_valid) begin
          m_sig  <= gf_step(m_sig, d_eff);
          m_left <= m_left - 1;
          if (m_left == 1) m_due <= 1'b1;
        end
      end else if (!m_done && start) begin
        m_sig  <= 8'h00;
        m_pass <= 1'b0;
        m_left <= int'(test_len);
        if (test_len == '0) m_due <= 1'b1;
      end
    end
  end

  // Hand-computed expectations for the coming negedge, posted by the stimulus.
  typedef struct packed {
    logic       chk_sig, chk_busy, chk_done, chk_pass;
    logic [7:0] sig;
    logic       busy, done, pass;
  } lit_t;
  lit_t lit = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_sig",  signature,      m_sig);
    chk("model_busy", {7'b0, busy},   {7'b0, m_busy});
    chk("model_done", {7'b0, done},   {7'b0, m_done});
    chk("model_pass", {7'b0, pass},   {7'b0, m_pass});
    if (lit.chk_sig)  chk("lit_sig",  signature,    lit.sig);
    if (lit.chk_busy) chk("lit_busy", {7'b0, busy}, {7'b0, lit.busy});
    if (lit.chk_done) chk("lit_done", {7'b0, done}, {7'b0, lit.done});
    if (lit.chk_pass) chk("lit_pass", {7'b0, pass}, {7'b0, lit.pass});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    lit = '0;
  endtask

  task automatic expect_lit(input logic [7:0] s, input logic b, input logic dn);
    lit.chk_sig  = 1'b1; lit.sig  = s;
    lit.chk_busy = 1'b1; lit.busy = b;
    lit.chk_done = 1'b1; lit.done = dn;
  endtask

  // Three-word run; gap>0 inserts idle cycles (with a stray start) before every word.
  task automatic do_run(input logic [LW-1:0] len, input logic [7:0] gold,
                        input logic [7:0] w [3], input int gap,
                        input logic [7:0] ex [3], input logic ex_pass);
    golden = gold; test_len = len; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < gap; g++) begin
        resp_valid = 1'b0; resp_data = 8'hA5; start = 1'b1; test_len = '0;
        cyc();
        start = 1'b0;
        lit.chk_busy = 1'b1; lit.busy = 1'b1;
      end
      resp_valid = 1'b1; resp_data = w[i];
`ifdef LBIST_MISR_XMASK_EN
      resp_mask = (i == 0) ? mask0 : 8'h00;
`endif
      cyc();
      resp_valid = 1'b0;
`ifdef LBIST_MISR_XMASK_EN
      resp_mask = 8'h00;
`endif
      expect_lit(ex[i], 1'b1, 1'b0);
    end
    cyc();
    expect_lit(ex[2], 1'b0, 1'b1);
    lit.chk_pass = 1'b1; lit.pass = ex_pass;
    cyc();
    expect_lit(ex[2], 1'b0, 1'b0);
    lit.chk_pass = 1'b1; lit.pass = ex_pass;
    cyc();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    expect_lit(8'h00, 1'b0, 1'b0);
    lit.chk_pass = 1'b1; lit.pass = 1'b0;
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    // Responses while idle must not disturb the signature.
    resp_valid = 1'b1; resp_data = 8'hFF;
    cyc();
    resp_valid = 1'b0;
    expect_lit(8'h00, 1'b0, 1'b0);
    cyc();

    do_run(16'd3, 8'h19, '{8'h01, 8'h80, 8'h00}, 0, '{8'h01, 8'h82, 8'h19}, 1'b1);
    do_run(16'd3, 8'h18, '{8'h01, 8'h80, 8'h00}, 0, '{8'h01, 8'h82, 8'h19}, 1'b0);
    do_run(16'd3, 8'h19, '{8'h01, 8'h80, 8'h00}, 2, '{8'h01, 8'h82, 8'h19}, 1'b1);

    // Zero length: CMP straight after start; a valid word during CMP is ignored.
    golden = 8'h00; test_len = '0; start = 1'b1;
    cyc();
    start = 1'b0; resp_valid = 1'b1; resp_data = 8'hAA;
    expect_lit(8'h00, 1'b1, 1'b0);
    cyc();
    resp_valid = 1'b0;
    expect_lit(8'h00, 1'b0, 1'b1);
    lit.chk_pass = 1'b1; lit.pass = 1'b1;
    cyc();
    cyc();

    // Reset after one accepted word: back to reset values, no done pulse.
    golden = 8'h19; test_len = 16'd3; start = 1'b1;
    cyc();
    start = 1'b0; resp_valid = 1'b1; resp_data = 8'h01;
    cyc();
    resp_valid = 1'b0;
    rst_n = 1'b0;
    expect_lit(8'h00, 1'b0, 1'b0);
    lit.chk_pass = 1'b1; lit.pass = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      expect_lit(8'h00, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    cyc();
    do_run(16'd3, 8'h19, '{8'h01, 8'h80, 8'h00}, 0, '{8'h01, 8'h82, 8'h19}, 1'b1);

`ifdef LBIST_MISR_XMASK_EN
    mask0 = 8'hFE;
    do_run(16'd3, 8'h19, '{8'hFF, 8'h80, 8'h00}, 0, '{8'h01, 8'h82, 8'h19}, 1'b1);
    mask0 = 8'h00;
`endif

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
